pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It replaces the fixed 16-bit single-cycle adder in wide datapaths. Operands are split into SEG_WIDTH-bit segments, and each segment's lookahead sum is computed in its own pipeline stage, with the carry registered between stages. Valid/ready handshakes sit on both sides, and the output carries carry, signed-overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SEG_WIDTH.
SEG_WIDTH, 8, bits per lookahead segment (1..16); STAGES = WIDTH/SEG_WIDTH.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  operand bundle valid.
in_ready  out  1  block accepts the bundle this cycle.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
cin  in  1  carry-in (for subtract: 1 = no borrow).
sub  in  1  0: a+b+cin; 1: a+~b+cin.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
sum  out  WIDTH  result.
cout  out  1  carry out of MSB.
ovf  out  1  signed overflow: (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is b after the sub inversion.
zero  out  1  sum == 0.

Behaviour:
- Interface statement (already decided): one clock, clk; reset is synchronous and active-high, reset.
- Reset: every stage valid bit cleared. Outputs after reset: out_valid=0, sum=0, cout=0, ovf=0, zero=0, in_ready=1.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, purely combinational from out_valid/out_ready and never from in_valid.
- Acceptance: in_valid && in_ready at a rising edge.
- Stage 1 register captures:
  - segment 0 sum from a, b' = sub ? ~b : b, and cin;
  - the segment 0 carry-out;
  - the remaining upper operand bits;
  - a partial zero flag.
- Stage k (2..STAGES) register: computes segment k-1 from the carry registered in stage k-1; passes on finished low bits, remaining operand bits and the accumulated zero flag.
- ovf is computed in the last segment from a[MSB], b'[MSB] and sum[MSB].
- Latency: a bundle accepted in cycle t gives out_valid=1 in cycle t+STAGES. STAGES=1 gives a simple registered adder with latency 1.
- Throughput: one result per clock while out_ready=1; results leave in acceptance order.
- Bubbles: a stage whose valid bit is 0 still shifts when adv=1. No compaction, so bubbles propagate.
- Backpressure: when out_valid && !out_ready, all stage registers and outputs hold, and in_ready=0. There is no loss and no duplication.
- Output stability: sum and flags stay stable while out_valid && !out_ready.
- Reset mid-operation: all in-flight results are discarded. out_valid=0 on the cycle after reset is sampled high, and the first new result appears STAGES cycles after the first post-reset acceptance.
- Reset and in_valid together: reset wins and the bundle is not accepted.
- Carry across segments: full ripple between stages through registered carry; lookahead inside a segment. Wrap-around is modulo 2^WIDTH, with the overflow reported in cout.
- Parameter violations (WIDTH % SEG_WIDTH != 0, or SEG_WIDTH outside 1..16): elaboration-time error, never silent truncation.

Decomposition:
- Shared package adder_pkg:
  - function num_stages(width, seg), returning STAGES;
  - localparam OP_ADD=1'b0, OP_SUB=1'b1;
  - parameter-check helper.
- Sub-module cla_segment: combinational SEG_WIDTH-bit carry-lookahead slice with P/G generation. Inputs a, b, cin; outputs s, cout. One instance per stage.
- pipelined_adder holds the pipeline registers, handshake and flag logic only.

Test Plan:
1. Carry through all segments (WIDTH=32, SEG=8): a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> after 4 cycles sum=0x0000_0000, cout=1, ovf=0, zero=1.
2. Subtract with overflow: a=0x8000_0000, b=0x0000_0001, sub=1, cin=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1, zero=0.
3. Streaming: 8 random bundles on consecutive cycles, out_ready=1 -> 8 results on consecutive cycles starting at cycle 4, in order, each matching a reference model.
4. Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> sum and flags frozen, in_ready=0, no bundle lost; after release all results drain in order.
5. Reset mid-flight: 3 bundles in flight, reset high for 1 cycle -> out_valid=0 the next cycle and no stale result ever appears; the next accepted bundle emerges exactly 4 cycles later.
6. Degenerate config (WIDTH=16, SEG_WIDTH=16): a=0x7FFF, b=0x0001, cin=0 -> latency 1, sum=0x8000, ovf=1, cout=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the segmented pipelined adder.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int num_stages(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit params_ok(input int width, input int seg);
        return (seg >= 1) && (seg <= 16) && (width >= seg) && (width % seg == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_cla.sv
// Combinational W-bit carry-lookahead slice: every carry is a flat sum of
// generate terms gated by the propagate chain below it.
module cla_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic         acc;
    logic         pp;

    always_comb begin
        p   = a ^ b;
        g   = a & b;
        c   = '0;
        acc = 1'b0;
        pp  = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & cin);
        end
        s    = p ^ c[W-1:0];
        cout = c[W];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Segmented adder/subtractor: one lookahead segment per stage, carry
// registered between stages, single global advance enable for backpressure.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = num_stages(WIDTH, SEG_WIDTH);

    if (!params_ok(WIDTH, SEG_WIDTH)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of SEG_WIDTH, SEG_WIDTH in 1..16");
    end

    logic                                  adv;
    logic [WIDTH-1:0]                      b_eff;
    logic [STAGES:1]                       vld_pipe;
    logic [STAGES:1][WIDTH-1:0]            a_q;
    logic [STAGES:1][WIDTH-1:0]            b_q;
    logic [STAGES:1][WIDTH-1:0]            s_q;
    logic [STAGES:1]                       c_q;
    logic [STAGES:1]                       z_q;
    logic                                  ovf_q;
    logic [STAGES-1:0][SEG_WIDTH-1:0]      seg_s;
    logic [STAGES-1:0]                     seg_c;
    logic                                  msb_a;
    logic                                  msb_b;

    assign b_eff     = (sub == OP_SUB) ? ~b : b;
    assign out_valid = vld_pipe[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        logic [SEG_WIDTH-1:0] sa;
        logic [SEG_WIDTH-1:0] sb;
        logic                 sc;
        if (k == 0) begin : g_first
            assign sa = a[0 +: SEG_WIDTH];
            assign sb = b_eff[0 +: SEG_WIDTH];
            assign sc = cin;
        end else begin : g_next
            assign sa = a_q[k][k*SEG_WIDTH +: SEG_WIDTH];
            assign sb = b_q[k][k*SEG_WIDTH +: SEG_WIDTH];
            assign sc = c_q[k];
        end
        cla_segment #(.W(SEG_WIDTH)) u_cla (
            .a    (sa),
            .b    (sb),
            .cin  (sc),
            .s    (seg_s[k]),
            .cout (seg_c[k])
        );
    end

    // Operand MSBs feeding the overflow check come from wherever the last segment reads.
    if (STAGES == 1) begin : g_msb_in
        assign msb_a = a[WIDTH-1];
        assign msb_b = b_eff[WIDTH-1];
    end else begin : g_msb_reg
        assign msb_a = a_q[STAGES-1][WIDTH-1];
        assign msb_b = b_q[STAGES-1][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            z_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            a_q[1]      <= a;
            b_q[1]      <= b_eff;
            s_q[1]      <= WIDTH'(seg_s[0]);
            c_q[1]      <= seg_c[0];
            z_q[1]      <= (seg_s[0] == '0);
            for (int k = 2; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                a_q[k]      <= a_q[k-1];
                b_q[k]      <= b_q[k-1];
                s_q[k]      <= s_q[k-1];
                s_q[k][(k-1)*SEG_WIDTH +: SEG_WIDTH] <= seg_s[k-1];
                c_q[k]      <= seg_c[k-1];
                z_q[k]      <= z_q[k-1] && (seg_s[k-1] == '0);
            end
            ovf_q <= (msb_a == msb_b) && (seg_s[STAGES-1][SEG_WIDTH-1] != msb_a);
        end
    end

    assign sum  = s_q[STAGES];
    assign cout = c_q[STAGES];
    assign zero = z_q[STAGES];
    assign ovf  = ovf_q;

endmodule
